// File: rtl/seq_gen_pkg.sv
// Shared constants for the serial pattern generator: FSM encoding and default sizes.
package seq_gen_pkg;

  localparam int unsigned DefPatW = 44;
  localparam int unsigned DefCntW = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_pattern_generator_if.sv
// Pattern-source bundle between a requester (master) and the generator (slave).
// Carries loop_in only when PATTERN_LOOP_EN is defined.
interface serial_pattern_generator_if import seq_gen_pkg::*; #(
  parameter int unsigned PAT_W = DefPatW,
  parameter int unsigned CNT_W = DefCntW
) ();

  logic             start;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] len_in;
  logic             mode_in;
  logic             stop;
`ifdef PATTERN_LOOP_EN
  logic             loop_in;
`endif
  logic             X;
  logic             x_valid;
  logic             M;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bits_left;

`ifdef PATTERN_LOOP_EN
  modport master (
    output start, pat_in, len_in, mode_in, stop, loop_in,
    input  X, x_valid, M, busy, done, bits_left
  );
  modport slave (
    input  start, pat_in, len_in, mode_in, stop, loop_in,
    output X, x_valid, M, busy, done, bits_left
  );
`else
  modport master (
    output start, pat_in, len_in, mode_in, stop,
    input  X, x_valid, M, busy, done, bits_left
  );
  modport slave (
    input  start, pat_in, len_in, mode_in, stop,
    output X, x_valid, M, busy, done, bits_left
  );
`endif

endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-load, left-shift register; msb_o is the registered serial output.
// Priority: clear, then load, then shift. Zeros fill from the LSB side.
module piso_shift_reg #(
  parameter int unsigned PAT_W = 44
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] data_i,
  output logic             msb_o
);

  logic [PAT_W-1:0] shreg_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb_o = shreg_q[PAT_W-1];

endmodule

// File: rtl/serial_pattern_generator.sv
// Serial pattern source for the sequence detector: shifts a parallel pattern out MSB first.
// Define PATTERN_LOOP_EN to add loop_in and gapless repeat of the latched pattern.
module serial_pattern_generator import seq_gen_pkg::*; #(
  parameter int unsigned PAT_W = DefPatW,
  parameter int unsigned CNT_W = DefCntW
) (
  input logic                       clk,
  input logic                       reset,
  serial_pattern_generator_if.slave bus_io
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] bits_left_q, bits_left_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             m_q, m_d;

  logic [CNT_W-1:0] len_clamped;
  logic [PAT_W-1:0] pat_aligned;
  logic [PAT_W-1:0] load_data;
  logic             sr_clear, sr_load, sr_shift, sr_msb;

  logic             loop_active;
  logic [PAT_W-1:0] reload_pat;
  logic [CNT_W-1:0] reload_len;

  assign len_clamped = (bus_io.len_in > CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : bus_io.len_in;
  // Left-justify the active bits so the first one to send sits at the MSB.
  assign pat_aligned = bus_io.pat_in << (PAT_W - 32'(len_clamped));

`ifdef PATTERN_LOOP_EN
  logic             loop_q;
  logic [PAT_W-1:0] pat_save_q;
  logic [CNT_W-1:0] len_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      loop_q     <= 1'b0;
      pat_save_q <= '0;
      len_q      <= '0;
    end else if (state_q == ST_IDLE && bus_io.start) begin
      loop_q     <= bus_io.loop_in;
      pat_save_q <= pat_aligned;
      len_q      <= len_clamped;
    end
  end

  assign loop_active = loop_q;
  assign reload_pat  = pat_save_q;
  assign reload_len  = len_q;
`else
  assign loop_active = 1'b0;
  assign reload_pat  = '0;
  assign reload_len  = '0;
`endif

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    x_valid_d   = x_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    m_d         = m_q;
    sr_clear    = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    load_data   = pat_aligned;

    case (state_q)
      ST_IDLE: begin
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        if (bus_io.start) begin
          sr_load     = 1'b1;
          bits_left_d = len_clamped;
          m_d         = bus_io.mode_in;
          if (len_clamped == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_SHIFT;
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (bus_io.stop) begin
          // Abort wins over completion and reload; no done pulse.
          sr_clear    = 1'b1;
          state_d     = ST_IDLE;
          x_valid_d   = 1'b0;
          busy_d      = 1'b0;
          bits_left_d = '0;
        end else if (bits_left_q > CNT_W'(1)) begin
          sr_shift    = 1'b1;
          bits_left_d = bits_left_q - CNT_W'(1);
        end else if (loop_active) begin
          sr_load     = 1'b1;
          load_data   = reload_pat;
          bits_left_d = reload_len;
          done_d      = 1'b1;
        end else begin
          sr_clear    = 1'b1;
          state_d     = ST_DONE;
          x_valid_d   = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          bits_left_d = '0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        sr_clear  = 1'b1;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bits_left_q <= '0;
      x_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      m_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      x_valid_q   <= x_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      m_q         <= m_d;
    end
  end

  piso_shift_reg #(
    .PAT_W (PAT_W)
  ) u_piso (
    .clk_i   (clk),
    .clear_i (sr_clear | ~reset),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (load_data),
    .msb_o   (sr_msb)
  );

  assign bus_io.X         = sr_msb;
  assign bus_io.x_valid   = x_valid_q;
  assign bus_io.M         = m_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;
  assign bus_io.bits_left = bits_left_q;

endmodule
